// File: rtl/tdet_pkg.sv
// Shared types and constants for the subcircuit stimulus/response driver.
package tdet_pkg;

    localparam int SIG_W = 16;

    localparam logic [SIG_W-1:0] LFSR_POLY_DEF     = 16'hB400;  // x^16+x^14+x^13+x^11+1
    localparam logic [SIG_W-1:0] MISR_POLY_DEF     = 16'h1021;  // CRC-16-CCITT
    localparam logic [SIG_W-1:0] ZERO_SEED_SUB_DEF = 16'hACE1;  // all-zero seed would lock up

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        SEND = 3'd2,
        WAIT = 3'd3,
        DONE = 3'd4
    } tdet_state_e;

    // One right-shifting Galois LFSR step.
    function automatic logic [SIG_W-1:0] galois_step(input logic [SIG_W-1:0] s,
                                                     input logic [SIG_W-1:0] poly);
        return (s >> 1) ^ (s[0] ? poly : '0);
    endfunction

    // One left-shifting MISR step absorbing a single response bit.
    function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] sig,
                                                   input logic [SIG_W-1:0] poly,
                                                   input logic             bit_in);
        return (sig << 1) ^ (sig[SIG_W-1] ? poly : '0) ^ {{(SIG_W-1){1'b0}}, bit_in};
    endfunction

endpackage

// File: rtl/lfsr16_galois.sv
// 16-bit Galois LFSR with synchronous load and advance controls.
// load has priority over advance; with neither asserted the state holds.
module lfsr16_galois
    import tdet_pkg::*;
#(
    parameter logic [15:0] POLY = LFSR_POLY_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] load_val,
    input  logic        advance,
    output logic [15:0] state
);

    logic [15:0] state_q;
    logic [15:0] state_d;

    // Select load value, next pseudo-random step, or hold
    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = load_val;
        end else if (advance) begin
            state_d = galois_step(state_q, POLY);
        end
    end

    // LFSR state register, cleared to zero on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= '0;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/subckt_stim_driver.sv
// Drives pseudo-random vectors into one extracted subcircuit, waits the
// fixed response latency, and compacts each response bit into a MISR.
//
// Handshake: a vector moves on every rising edge where vec_valid && vec_ready.
// vec_valid is asserted only in SEND, never depends combinationally on
// vec_ready, and vec_data is held stable until the transfer edge. Only one
// vector is ever in flight; the next is offered after its response is taken.
module subckt_stim_driver
    import tdet_pkg::*;
#(
    parameter int                WIDTH         = 7,
    parameter int                RESP_LAT      = 2,
    parameter logic [SIG_W-1:0]  LFSR_POLY     = LFSR_POLY_DEF,
    parameter logic [SIG_W-1:0]  MISR_POLY     = MISR_POLY_DEF,
    parameter logic [SIG_W-1:0]  ZERO_SEED_SUB = ZERO_SEED_SUB_DEF
) (
    input  logic             I1470_clk,
    input  logic             I1477_rst,
    input  logic             start,
    input  logic [15:0]      seed,
    input  logic [15:0]      num_patterns,
    output logic             vec_valid,
    input  logic             vec_ready,
    output logic [WIDTH-1:0] vec_data,
    input  logic             resp_bit,
    output logic             busy,
    output logic             done,
    output logic [SIG_W-1:0] signature
);

    localparam logic [3:0] LAT_INIT = 4'(RESP_LAT);

    tdet_state_e      state_q, state_d;
    logic [15:0]      rem_q, rem_d;
    logic [15:0]      seed_q, seed_d;
    logic [SIG_W-1:0] sig_q, sig_d;
    logic [3:0]       lat_q, lat_d;

    logic             lfsr_load;
    logic             lfsr_adv;
    logic [15:0]      lfsr_seed;
    logic [15:0]      lfsr_state;
    logic             lfsr_bits_unused;

    // A zero seed is replaced so the LFSR never starts in its lock-up state.
    assign lfsr_seed = (seed_q == '0) ? ZERO_SEED_SUB : seed_q;

    lfsr16_galois #(
        .POLY (LFSR_POLY)
    ) u_lfsr (
        .clk      (I1470_clk),
        .rst_n    (I1477_rst),
        .load     (lfsr_load),
        .load_val (lfsr_seed),
        .advance  (lfsr_adv),
        .state    (lfsr_state)
    );

    // Bits above WIDTH only feed the LFSR recurrence, never the SUT.
    assign lfsr_bits_unused = ^lfsr_state;

    // Next-state decode plus counter, MISR and LFSR control
    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        seed_d    = seed_q;
        sig_d     = sig_q;
        lat_d     = lat_q;
        lfsr_load = 1'b0;
        lfsr_adv  = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = LOAD;
                    rem_d   = num_patterns;
                    seed_d  = seed;
                    sig_d   = '0;
                end
            end

            LOAD: begin
                lfsr_load = 1'b1;
                state_d   = (rem_q == '0) ? DONE : SEND;
            end

            SEND: begin
                if (vec_ready) begin
                    lfsr_adv = 1'b1;
                    if (rem_q != '0) begin
                        rem_d = rem_q - 16'd1;
                    end
                    lat_d   = LAT_INIT;
                    state_d = WAIT;
                end
            end

            WAIT: begin
                // lat_q reaches 1 on the edge RESP_LAT cycles after transfer.
                if (lat_q <= 4'd1) begin
                    sig_d   = misr_step(sig_q, MISR_POLY, resp_bit);
                    lat_d   = '0;
                    state_d = (rem_q != '0) ? SEND : DONE;
                end else begin
                    lat_d = lat_q - 4'd1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control and datapath registers, all cleared by reset
    always_ff @(posedge I1470_clk or negedge I1477_rst) begin
        if (!I1477_rst) begin
            state_q <= IDLE;
            rem_q   <= '0;
            seed_q  <= '0;
            sig_q   <= '0;
            lat_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            seed_q  <= seed_d;
            sig_q   <= sig_d;
            lat_q   <= lat_d;
        end
    end

    assign vec_valid = (state_q == SEND);
    assign vec_data  = vec_valid ? lfsr_state[WIDTH-1:0] : '0;
    assign busy      = (state_q == LOAD) || (state_q == SEND) || (state_q == WAIT);
    assign done      = (state_q == DONE);
    assign signature = sig_q;

endmodule

// File: tb/tb_subckt_stim_driver.sv
// Directed bench for subckt_stim_driver: a transaction-level model of the
// vector stream and signature, checked every cycle, plus literal pins.
module tb_subckt_stim_driver;

    localparam int WIDTH    = 7;
    localparam int RESP_LAT = 2;

    logic             clk          = 1'b0;
    logic             rst_n        = 1'b1;
    logic             start        = 1'b0;
    logic [15:0]      seed         = '0;
    logic [15:0]      num_patterns = '0;
    logic             vec_ready    = 1'b1;
    logic             resp_bit     = 1'b0;
    logic             vec_valid;
    logic [WIDTH-1:0] vec_data;
    logic             busy;
    logic             done;
    logic [15:0]      signature;

    int errors = 0;
    int checks = 0;

    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] seen_q[$];
    logic [15:0]      exp_sig   = '0;
    bit               sig_armed = 1'b0;
    bit               prev_xfer = 1'b0;

    subckt_stim_driver #(
        .WIDTH    (WIDTH),
        .RESP_LAT (RESP_LAT)
    ) dut (
        .I1470_clk    (clk),
        .I1477_rst    (rst_n),
        .start        (start),
        .seed         (seed),
        .num_patterns (num_patterns),
        .vec_valid    (vec_valid),
        .vec_ready    (vec_ready),
        .vec_data     (vec_data),
        .resp_bit     (resp_bit),
        .busy         (busy),
        .done         (done),
        .signature    (signature)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        logic [15:0] r;
        r = s >> 1;
        if (s[0]) r = r ^ 16'hB400;
        return r;
    endfunction

    function automatic logic [15:0] misr_next(input logic [15:0] g, input logic b);
        logic [15:0] r;
        r = {g[14:0], 1'b0};
        if (g[15]) r = r ^ 16'h1021;
        r[0] = r[0] ^ b;
        return r;
    endfunction

    // Expected vector list and final signature for one complete run.
    function automatic void build_model(input logic [15:0] s, input int n, input logic [15:0] bits);
        logic [15:0] cur;
        logic [15:0] g;
        exp_q.delete();
        cur = (s == 16'h0) ? 16'hACE1 : s;
        g   = 16'h0;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(cur[WIDTH-1:0]);
            cur = lfsr_next(cur);
            g   = misr_next(g, bits[i]);
        end
        exp_sig = g;
    endfunction

    // Compare process: DUT outputs against the model every cycle
    always @(negedge clk) begin
        if (!rst_n) begin
            check("reset_outputs", {vec_valid, vec_data, busy, done, signature}, 32'h0);
            exp_q.delete();
            sig_armed = 1'b0;
            prev_xfer = 1'b0;
        end else begin
            if (prev_xfer) check("valid_drops_after_xfer", vec_valid, 1'b0);
            if (vec_valid) begin
                check("valid_implies_busy", busy, 1'b1);
                check("vector_expected", (exp_q.size() != 0), 1'b1);
                if (exp_q.size() != 0) begin
                    check("vec_data", vec_data, exp_q[0]);
                    if (vec_ready) void'(exp_q.pop_front());
                end
                if (vec_ready) seen_q.push_back(vec_data);
            end
            if (done) begin
                check("busy_low_in_done", busy, 1'b0);
                if (sig_armed) begin
                    check("signature", signature, exp_sig);
                    check("all_vectors_sent", exp_q.size(), 0);
                end
            end
            prev_xfer = vec_valid && vec_ready;
        end
    end

    // Driver: one run; optional stall on the first vector, start injection
    // after transfer inject_at, or reset abort after transfer abort_at.
    task automatic run_one(input logic [15:0] s, input int n, input logic [15:0] bits,
                           input int stall, input int inject_at, input int abort_at,
                           output int latency);
        int cyc;
        int k;
        int cd;
        int stall_left;
        bit active;
        bit cur;
        bit xfer;
        latency    = -1;
        k          = 0;
        cd         = 0;
        active     = 1'b0;
        cur        = 1'b0;
        stall_left = stall;
        seen_q.delete();
        @(posedge clk); #1;
        start        = 1'b1;
        seed         = s;
        num_patterns = 16'(n);
        vec_ready    = (stall_left == 0);
        @(posedge clk); #1;
        start        = 1'b0;
        seed         = 16'($urandom);
        num_patterns = 16'($urandom);
        build_model(s, n, bits);
        sig_armed = 1'b1;
        check("done_falls_on_start", done, 1'b0);
        check("busy_after_start", busy, 1'b1);
        cyc = 0;
        forever begin
            @(negedge clk);
            if (done) begin
                latency = cyc;
                break;
            end
            if (cyc > 300) begin
                check("run_timeout", 1'b0, 1'b1);
                break;
            end
            xfer = vec_valid && vec_ready;
            if (vec_valid && stall_left > 0) stall_left--;
            @(posedge clk);
            cyc++;
            #1;
            if (xfer) begin
                k++;
                cd     = RESP_LAT - 1;
                active = 1'b1;
                cur    = bits[k-1];
            end
            // Correct bit only in the cycle before the sampling edge.
            if (active) begin
                if (cd == 0) begin
                    resp_bit = cur;
                    active   = 1'b0;
                end else begin
                    resp_bit = ~cur;
                    cd--;
                end
            end else begin
                resp_bit = 1'($urandom_range(0, 1));
            end
            vec_ready = (stall_left == 0);
            start     = xfer && (k == inject_at);
            if (start) begin
                seed         = 16'($urandom);
                num_patterns = 16'($urandom_range(1, 9));
            end
            if (xfer && k == abort_at) begin
                #2;
                rst_n = 1'b0;
                #1;
                check("abort_async_zero", {vec_valid, vec_data, busy, done, signature}, 32'h0);
                repeat (3) @(posedge clk);
                #3;
                rst_n = 1'b1;
                return;
            end
        end
    endtask

    initial begin
        int lat;
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_async", {vec_valid, vec_data, busy, done, signature}, 32'h0);
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b1;

        // Model pins
        check("pin_lfsr_a", lfsr_next(16'h00FF), 16'hB47F);
        check("pin_lfsr_b", lfsr_next(16'hB47F), 16'hEE3F);
        check("pin_misr_a", misr_next(16'h0000, 1'b1), 16'h0001);
        check("pin_misr_b", misr_next(16'h0001, 1'b1), 16'h0003);

        // Three back-to-back vectors at full rate
        run_one(16'h00FF, 3, 16'b101, 0, -1, -1, lat);
        check("latency_3pat", lat, 10);
        check("seen_count_3pat", seen_q.size(), 3);
        if (seen_q.size() == 3) begin
            check("vec0_lit", seen_q[0], 7'h7F);
            check("vec1_lit", seen_q[1], 7'h7F);
            check("vec2_lit", seen_q[2], 7'h3F);
        end

        // Signature literals (restart from DONE)
        run_one(16'h1234, 1, 16'h0001, 0, -1, -1, lat);
        check("sig_one_lit", signature, 16'h0001);
        run_one(16'h4321, 2, 16'h0003, 0, -1, -1, lat);
        check("sig_two_lit", signature, 16'h0003);

        // Zero seed substitution
        run_one(16'h0000, 1, 16'h0000, 0, -1, -1, lat);
        check("zero_seed_count", seen_q.size(), 1);
        if (seen_q.size() == 1) check("zero_seed_vec_lit", seen_q[0], 7'h61);

        // Backpressure on the first vector
        run_one(16'h5A5A, 2, 16'b10, 5, -1, -1, lat);
        check("latency_stall", lat, 12);

        // Empty run
        run_one(16'hBEEF, 0, 16'h0000, 0, -1, -1, lat);
        check("latency_empty", lat, 1);
        check("sig_empty_lit", signature, 16'h0000);
        check("no_vectors_empty", seen_q.size(), 0);

        // start during WAIT is ignored
        run_one(16'h1357, 4, 16'b1011, 0, 2, -1, lat);
        check("latency_inject", lat, 13);

        // Reset abort mid-run, then a clean rerun
        run_one(16'hC0DE, 4, 16'b0110, 0, -1, 2, lat);
        run_one(16'hC0DE, 4, 16'b0110, 0, -1, -1, lat);
        check("latency_after_abort", lat, 13);
        check("sig_after_abort", signature, exp_sig);

        // Longer runs with varied seeds and responses
        for (int i = 0; i < 4; i++) begin
            run_one(16'($urandom), $urandom_range(5, 16), 16'($urandom), $urandom_range(0, 3), -1, -1, lat);
        end

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
